// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register indices, STAT/IEN bit positions and FSM encodings shared by the UART block
package uart_mmio_pkg;
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;
    localparam logic [1:0] REG_IEN  = 2'd3;

    localparam int STAT_TX_BUSY  = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_RX_VALID = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_RXOVR    = 4;
    localparam int STAT_FERR     = 5;
    localparam int STAT_TXOVF    = 6;

    localparam int IEN_RX  = 0;
    localparam int IEN_TX  = 1;
    localparam int IEN_ERR = 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: IO-page register bus (sel/addr/rstrb/wstrb/wdata in, registered rdata out)
interface uart_mmio_if;
    logic        sel;
    logic [1:0]  addr;
    logic        rstrb;
    logic        wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output sel, addr, rstrb, wstrb, wdata, input rdata);
    modport slave  (input sel, addr, rstrb, wstrb, wdata, output rdata);
endinterface

// File: rtl/uart_mmio_sync_fifo.sv
// sync_fifo: show-ahead FIFO; ports clk, reset, push/din, pop/head, full, empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign empty = wp == rp;
    assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign do_pop = pop && !empty;
    // a push on a full FIFO still lands when a pop frees the slot in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped full-duplex UART; ports clk, reset, bus (slave), rx in, tx out, irq out
module uart_mmio import uart_mmio_pkg::*; #(
    parameter int DEFAULT_DIV = 234,
    parameter int FIFO_DEPTH  = 16,
    parameter int MIN_DIV     = 4
) (
    input  logic       clk,
    input  logic       reset,
    uart_mmio_if.slave bus,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);
    logic [15:0] div;
    logic [2:0]  ien;
    logic        rxovr, ferr, txovf;
    logic        rd, wr, tx_full, tx_empty, tx_pop, tx_push, rx_full, rx_empty, rx_pop, rx_push, rx_ferr;
    logic [7:0]  tx_head, rx_head, tx_sh, rx_sh;
    logic [2:0]  stat_clr, tx_bit, rx_bit;
    logic [31:0] stat, rd_val;
    logic [15:0] tx_cnt, tx_bdiv, rx_cnt, rx_bdiv;
    logic        tx_end, rx_end, rx_half, rx_s1, rx_s, rx_q;
    logic        unused_bits;
    tx_state_t   tx_st;
    rx_state_t   rx_st;

    assign rd = bus.sel && bus.rstrb;
    assign wr = bus.sel && bus.wstrb;
    assign tx_push = wr && bus.addr == REG_DATA;
    assign rx_pop = rd && bus.addr == REG_DATA && !rx_empty;
    assign stat_clr = wr && bus.addr == REG_STAT ? bus.wdata[6:4] : 3'd0;
    assign unused_bits = ^bus.wdata[31:16];
    // bit length is latched per bit, so a DIV write only takes hold at the next bit boundary
    assign tx_end = tx_cnt == tx_bdiv - 16'd1;
    assign rx_end = rx_cnt == rx_bdiv - 16'd1;
    assign rx_half = rx_cnt == (rx_bdiv >> 1) - 16'd1;
    assign tx_pop = !tx_empty && (tx_st == TX_IDLE || (tx_st == TX_STOP && tx_end));

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(bus.wdata[7:0]),
        .head(tx_head), .full(tx_full), .empty(tx_empty)
    );
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_sh),
        .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        stat = '0;
        stat[STAT_TX_BUSY] = !tx_empty || tx_st != TX_IDLE;
        stat[STAT_TX_FULL] = tx_full;
        stat[STAT_RX_VALID] = !rx_empty;
        stat[STAT_RX_FULL] = rx_full;
        stat[STAT_RXOVR] = rxovr;
        stat[STAT_FERR] = ferr;
        stat[STAT_TXOVF] = txovf;
        rd_val = bus.addr == REG_DATA ? (rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head}) :
                 bus.addr == REG_STAT ? stat :
                 bus.addr == REG_DIV  ? {16'd0, div} : {29'd0, ien};
    end

    // registers, sticky flags (set beats W1C clear) and the registered irq
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            div <= 16'(DEFAULT_DIV);
            ien <= '0;
            rxovr <= 1'b0;
            ferr <= 1'b0;
            txovf <= 1'b0;
            bus.rdata <= '0;
            irq <= 1'b0;
        end else begin
            if (wr && bus.addr == REG_DIV)
                div <= bus.wdata[15:0] < 16'(MIN_DIV) ? 16'(MIN_DIV) : bus.wdata[15:0];
            if (wr && bus.addr == REG_IEN) ien <= bus.wdata[2:0];
            rxovr <= (rx_push && rx_full && !rx_pop) || (rxovr && !stat_clr[0]);
            ferr <= rx_ferr || (ferr && !stat_clr[1]);
            txovf <= (tx_push && tx_full && !tx_pop) || (txovf && !stat_clr[2]);
            if (rd) bus.rdata <= rd_val;
            irq <= (ien[IEN_RX] && !rx_empty) || (ien[IEN_TX] && tx_empty) ||
                   (ien[IEN_ERR] && (rxovr || ferr || txovf));
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tx_st <= TX_IDLE;
            tx <= 1'b1;
            tx_cnt <= '0;
            tx_bdiv <= 16'(DEFAULT_DIV);
            tx_bit <= '0;
            tx_sh <= '0;
        end else
            case (tx_st)
                TX_IDLE:
                    if (tx_pop) begin
                        tx_st <= TX_START;
                        tx <= 1'b0;
                        tx_sh <= tx_head;
                        tx_cnt <= '0;
                        tx_bdiv <= div;
                    end
                TX_START:
                    if (tx_end) begin
                        tx_st <= TX_DATA;
                        tx <= tx_sh[0];
                        tx_bit <= '0;
                        tx_cnt <= '0;
                        tx_bdiv <= div;
                    end else tx_cnt <= tx_cnt + 16'd1;
                TX_DATA:
                    if (tx_end) begin
                        tx_cnt <= '0;
                        tx_bdiv <= div;
                        tx_bit <= tx_bit + 3'd1;
                        tx_sh <= tx_sh >> 1;
                        tx <= tx_bit == 3'd7 ? 1'b1 : tx_sh[1];
                        if (tx_bit == 3'd7) tx_st <= TX_STOP;
                    end else tx_cnt <= tx_cnt + 16'd1;
                TX_STOP:
                    if (tx_end) begin
                        tx_cnt <= '0;
                        tx_bdiv <= div;
                        // queued byte starts immediately: no idle bit between frames
                        tx_st <= tx_pop ? TX_START : TX_IDLE;
                        tx <= !tx_pop;
                        if (tx_pop) tx_sh <= tx_head;
                    end else tx_cnt <= tx_cnt + 16'd1;
                default: tx_st <= TX_IDLE;
            endcase

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
            rx_st <= RX_IDLE;
            rx_cnt <= '0;
            rx_bdiv <= 16'(DEFAULT_DIV);
            rx_bit <= '0;
            rx_sh <= '0;
            rx_push <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s <= rx_s1;
            rx_q <= rx_s;
            rx_push <= 1'b0;
            rx_ferr <= 1'b0;
            case (rx_st)
                RX_IDLE:
                    if (rx_q && !rx_s) begin
                        rx_st <= RX_START;
                        rx_cnt <= '0;
                        rx_bdiv <= div;
                    end
                RX_START:
                    // mid-start check rejects glitches shorter than half a bit
                    if (rx_half) begin
                        rx_st <= rx_s ? RX_IDLE : RX_DATA;
                        rx_cnt <= '0;
                        rx_bdiv <= div;
                        rx_bit <= '0;
                    end else rx_cnt <= rx_cnt + 16'd1;
                RX_DATA:
                    if (rx_end) begin
                        rx_cnt <= '0;
                        rx_bdiv <= div;
                        rx_sh <= {rx_s, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_st <= RX_STOP;
                    end else rx_cnt <= rx_cnt + 16'd1;
                RX_STOP:
                    if (rx_end) begin
                        rx_push <= rx_s;
                        rx_ferr <= !rx_s;
                        rx_st <= rx_s ? RX_IDLE : RX_WAIT;
                    end else rx_cnt <= rx_cnt + 16'd1;
                RX_WAIT:
                    if (rx_s) rx_st <= RX_IDLE;
                default: rx_st <= RX_IDLE;
            endcase
        end
endmodule
